ulpi_reg_read: RTL and testbench

- Link-side ULPI register-read initiator for the USB3300 sniffer; counterpart of the register-write block, sharing the same ULPI bus arbitration.
- On a read request it issues a RegRead TX CMD, handles the two bus turnarounds and captures the PHY's register data.
- It returns the byte to the controller with a done pulse.
- It recovers from the PHY seizing the bus (RX CMD abort) by retrying, and from a silent PHY by timeout.

---
 rtl/ulpi_pkg.sv | 31 +++
 rtl/ulpi_reg_read.sv | 189 ++++++++++++++++++
 tb/tb_ulpi_reg_read.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions for the link-side register access blocks
// (TX CMD prefixes, bus width, register-access state encoding).
package ulpi_pkg;

  localparam int unsigned ULPI_DATA_W = 8;

  localparam logic [1:0] TXCMD_REG_WRITE = 2'b10;
  localparam logic [1:0] TXCMD_REG_READ  = 2'b11;
  localparam logic [7:0] TXCMD_NOOP      = 8'h00;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_CMD_ENC   = 3'd1;
  localparam logic [2:0] ST_TURN_ENC  = 3'd2;
  localparam logic [2:0] ST_READ_ENC  = 3'd3;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd4;
  localparam logic [2:0] ST_ABORT_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE         = ST_IDLE_ENC,
    ST_CMD          = ST_CMD_ENC,
    ST_TURN         = ST_TURN_ENC,
    ST_READ         = ST_READ_ENC,
    ST_WAIT_RELEASE = ST_WAIT_ENC,
    ST_ABORT        = ST_ABORT_ENC
  } reg_state_e;

  function automatic logic [7:0] tx_cmd(input logic [1:0] prefix, input logic [5:0] addr);
    return {prefix, addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_read.sv
// Link-side ULPI register-read initiator: issues a RegRead TX CMD, handles both
// bus turnarounds, captures the PHY's data and retries on RX CMD aborts.
module ulpi_reg_read
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                   clk_ULPI,
  input  logic                   rst,
  input  logic                   PrR,
  input  logic [5:0]             ADDR,
  output logic                   busy,
  output logic [ULPI_DATA_W-1:0] REG_VAL,
  output logic                   done,
  output logic                   err,
  input  logic                   DIR,
  input  logic                   NXT,
  input  logic [ULPI_DATA_W-1:0] DATA_I,
  output logic [ULPI_DATA_W-1:0] DATA_O,
  output logic                   STP
);

  reg_state_e             state_r, state_s;
  logic [5:0]             addr_r, addr_s;
  logic                   pend_r;
  logic [3:0]             retry_r;
  logic [7:0]             tmo_r;
  logic [ULPI_DATA_W-1:0] reg_val_r, data_o_r;
  logic                   done_r, err_r, busy_r;
  logic                   done_s, err_s, accept_s, pend_set_s, retry_inc_s, tmo_hit_s;

  assign tmo_hit_s = (tmo_r == 8'(TIMEOUT - 1));

  // Next-state decode and single-cycle done/err requests
  always_comb begin
    state_s     = state_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    accept_s    = 1'b0;
    pend_set_s  = 1'b0;
    retry_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!DIR && (PrR || pend_r)) begin
          accept_s = 1'b1;
          state_s  = ST_CMD;
        end else if (DIR && PrR) begin
          pend_set_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        // DIR high while our TX CMD is out means the PHY grabbed the bus
        if (!DIR && NXT) begin
          state_s = ST_TURN;
        end else if (DIR) begin
          state_s = ST_ABORT;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_TURN: begin
        if (DIR) begin
          state_s = ST_READ;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_TURN;
        end
      end
      ST_READ: begin
        if (DIR && !NXT) begin
          done_s  = 1'b1;
          state_s = ST_WAIT_RELEASE;
        end else if (DIR) begin
          state_s = ST_ABORT;
        end else begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!DIR) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_RELEASE;
        end
      end
      ST_ABORT: begin
        // No timeout here: the PHY may stream RX data for a long time
        if (!DIR) begin
          if (retry_r >= 4'(MAX_RETRY)) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            retry_inc_s = 1'b1;
            state_s     = ST_CMD;
          end
        end else begin
          state_s = ST_ABORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Address is captured with the request, even when it has to wait for DIR low
  always_comb begin
    if (state_r == ST_IDLE && PrR && !pend_r) begin
      addr_s = ADDR;
    end else begin
      addr_s = addr_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_ULPI or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= 6'h00;
      pend_r    <= 1'b0;
      retry_r   <= 4'h0;
      tmo_r     <= 8'h00;
      reg_val_r <= 8'h00;
      data_o_r  <= 8'h00;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      done_r  <= done_s;
      err_r   <= err_s;
      busy_r  <= (state_s != ST_IDLE);

      if (accept_s) begin
        pend_r <= 1'b0;
      end else if (pend_set_s) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end

      if (accept_s) begin
        retry_r <= 4'h0;
      end else if (retry_inc_s) begin
        retry_r <= retry_r + 4'h1;
      end else begin
        retry_r <= retry_r;
      end

      if (state_s != state_r) begin
        tmo_r <= 8'h00;
      end else if (tmo_r != 8'hFF) begin
        tmo_r <= tmo_r + 8'h01;
      end else begin
        tmo_r <= tmo_r;
      end

      if (done_s) begin
        reg_val_r <= DATA_I;
      end else begin
        reg_val_r <= reg_val_r;
      end

      if (state_s == ST_CMD) begin
        data_o_r <= tx_cmd(TXCMD_REG_READ, addr_s);
      end else begin
        data_o_r <= TXCMD_NOOP;
      end
    end
  end

  assign busy    = busy_r;
  assign REG_VAL = reg_val_r;
  assign done    = done_r;
  assign err     = err_r;
  assign DATA_O  = data_o_r;
  assign STP     = 1'b0;

endmodule

// File: tb/tb_ulpi_reg_read.sv
// Directed bench for ulpi_reg_read: stimulus pushes expected done/err events
// into a scoreboard queue, a monitor pops and compares them as the DUT pulses.
module tb_ulpi_reg_read;

  logic       clk_ULPI = 1'b0;
  logic       rst      = 1'b0;
  logic       PrR      = 1'b0;
  logic [5:0] ADDR     = 6'h00;
  logic       DIR      = 1'b0;
  logic       NXT      = 1'b0;
  logic [7:0] DATA_I   = 8'h00;
  logic       busy, done, err, STP;
  logic [7:0] REG_VAL, DATA_O;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ulpi_reg_read #(.TIMEOUT(64), .MAX_RETRY(3)) dut (
    .clk_ULPI(clk_ULPI), .rst(rst), .PrR(PrR), .ADDR(ADDR),
    .busy(busy), .REG_VAL(REG_VAL), .done(done), .err(err),
    .DIR(DIR), .NXT(NXT), .DATA_I(DATA_I), .DATA_O(DATA_O), .STP(STP)
  );

  always #5 clk_ULPI = ~clk_ULPI;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_ULPI);
    #1;
  endtask

  task automatic push(input bit is_err, input logic [7:0] val);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    sb_q.push_back(e);
  endtask

  // PHY side of a clean read, starting with the TX CMD already on the bus
  task automatic handshake(input logic [7:0] val);
    push(1'b0, val);
    NXT = 1'b1;
    tick();
    chk("turn_data_o", DATA_O, 8'h00);
    NXT = 1'b0;
    DIR = 1'b1;
    tick();
    DATA_I = val;
    tick();
    chk("done_latency", {7'h00, done}, 8'h01);
    chk("busy_wait_release", {7'h00, busy}, 8'h01);
    DATA_I = 8'h00;
    DIR    = 1'b0;
    tick();
    chk("busy_after_release", {7'h00, busy}, 8'h00);
  endtask

  // Scoreboard monitor, sampling mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_ULPI);
      if (rst) begin
        chk("stp_low", {7'h00, STP}, 8'h00);
        if (done || err) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got done=%b err=%b expected no pulse", done, err);
          end else begin
            e = sb_q.pop_front();
            chk("sb_done", {7'h00, done}, {7'h00, !e.is_err});
            chk("sb_err", {7'h00, err}, {7'h00, e.is_err});
            chk("sb_reg_val", REG_VAL, e.val);
          end
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_busy", {7'h00, busy}, 8'h00);
    chk("rst_reg_val", REG_VAL, 8'h00);
    chk("rst_done", {7'h00, done}, 8'h00);
    chk("rst_err", {7'h00, err}, 8'h00);
    chk("rst_data_o", DATA_O, 8'h00);
    chk("rst_stp", {7'h00, STP}, 8'h00);
    tick();
    rst = 1'b1;
    tick();

    // 1: plain read of 0x16 returning 0xAF
    ADDR = 6'h16;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    chk("t1_txcmd", DATA_O, 8'hD6);
    chk("t1_busy", {7'h00, busy}, 8'h01);
    handshake(8'hAF);
    chk("t1_reg_val", REG_VAL, 8'hAF);

    // 2: PHY seizes bus during CMD for 5 cycles, then a clean retry
    ADDR = 6'h2F;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    chk("t2_txcmd", DATA_O, 8'hEF);
    DIR = 1'b1;
    repeat (5) tick();
    chk("t2_abort_data_o", DATA_O, 8'h00);
    DIR = 1'b0;
    tick();
    chk("t2_txcmd_reissue", DATA_O, 8'hEF);
    handshake(8'hBA);
    chk("t2_reg_val", REG_VAL, 8'hBA);

    // 3: four aborts in a row exhaust MAX_RETRY=3
    ADDR = 6'h05;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      DIR = 1'b1;
      tick();
      tick();
      if (i == 3) push(1'b1, 8'hBA);
      DIR = 1'b0;
      tick();
    end
    chk("t3_err_pulse", {7'h00, err}, 8'h01);
    chk("t3_busy", {7'h00, busy}, 8'h00);
    tick();
    chk("t3_reg_val", REG_VAL, 8'hBA);

    // 4: NXT never comes, err after 64 cycles in CMD
    ADDR = 6'h01;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    repeat (63) tick();
    chk("t4_no_err_yet", {7'h00, err}, 8'h00);
    chk("t4_txcmd_held", DATA_O, 8'hC1);
    push(1'b1, 8'hBA);
    tick();
    chk("t4_err_at_64", {7'h00, err}, 8'h01);
    chk("t4_data_o_idle", DATA_O, 8'h00);
    tick();
    chk("t4_busy", {7'h00, busy}, 8'h00);

    // 5: reset while in READ, then a normal read of 0x2C
    ADDR = 6'h03;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    NXT = 1'b1;
    tick();
    NXT = 1'b0;
    DIR = 1'b1;
    tick();
    DATA_I = 8'h55;
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_busy", {7'h00, busy}, 8'h00);
    chk("t5_rst_reg_val", REG_VAL, 8'h00);
    chk("t5_rst_done", {7'h00, done}, 8'h00);
    chk("t5_rst_data_o", DATA_O, 8'h00);
    tick();
    rst    = 1'b1;
    DIR    = 1'b0;
    DATA_I = 8'h00;
    tick();
    chk("t5_no_done", {7'h00, done}, 8'h00);
    ADDR = 6'h2C;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    chk("t5_txcmd", DATA_O, 8'hEC);
    handshake(8'hA1);
    chk("t5_reg_val", REG_VAL, 8'hA1);

    // 6: request while DIR=1 waits; PrR during busy is dropped
    DIR  = 1'b1;
    ADDR = 6'h0A;
    PrR  = 1'b1;
    tick();
    PrR  = 1'b0;
    ADDR = 6'h3F;
    tick();
    chk("t6_pending_busy", {7'h00, busy}, 8'h00);
    chk("t6_pending_data_o", DATA_O, 8'h00);
    DIR = 1'b0;
    tick();
    chk("t6_txcmd", DATA_O, 8'hCA);
    chk("t6_busy", {7'h00, busy}, 8'h01);
    ADDR = 6'h11;
    PrR  = 1'b1;
    tick();
    PrR = 1'b0;
    chk("t6_txcmd_kept", DATA_O, 8'hCA);
    handshake(8'h77);
    repeat (6) tick();
    chk("t6_idle_busy", {7'h00, busy}, 8'h00);
    chk("t6_idle_data_o", DATA_O, 8'h00);
    chk("t6_reg_val", REG_VAL, 8'h77);

    repeat (2) tick();
    chk("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
